conv_linebuf_k: RTL and testbench

Parametrised K-row line buffer for the streaming convolution path. It is the generalised successor of the fixed 3-row, 16-bit, 418-pixel shift register. Each accepted pixel produces a vertical column of ROWS pixels (newest row first) one cycle later, ready for the horizontal window stage. Added capabilities:
- configurable depth, width and line length
- selectable top-border padding
- frame-start clear
- short-line detection

---
 rtl/conv_pkg.sv | 20 ++
 rtl/linebuf_ram.sv | 36 +++
 rtl/conv_linebuf_k.sv | 148 ++++++++++++++
 tb/tb_conv_linebuf_k.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and helpers for the streaming convolution path.
package conv_pkg;

  localparam int PAD_NONE = 0;
  localparam int PAD_ZERO = 1;
  localparam int PAD_REPL = 2;

  localparam int MAX_ROWS = 7;

  // Never returns less than 1 so it can size a port even for tiny depths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/linebuf_ram.sv
// Single-port line RAM, read-first, synchronous read; shaped for block-RAM inference.
module linebuf_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 418,
  parameter int ADDR_W = 9
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en && i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Only the output register is reset, so a fresh block shows zero columns.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_en) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/conv_linebuf_k.sv
// K-row line buffer: one vertical column of ROWS pixels per accepted pixel, one cycle later.
module conv_linebuf_k
  import conv_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int LINE_W   = 418,
  parameter int ROWS     = 3,
  parameter int PAD_MODE = 0,
  localparam int COL_W   = clog2(LINE_W)
) (
  input  logic                   i_pclk,
  input  logic                   i_rst,
  input  logic                   i_sof,
  input  logic                   i_wr_en,
  input  logic [DATA_W-1:0]      i_wr_data,
  input  logic                   i_rd_hs,
  input  logic                   i_rd_en,
  output logic [ROWS*DATA_W-1:0] o_rows_out,
  output logic                   o_out_valid,
  output logic [COL_W-1:0]       o_out_col,
  output logic                   o_out_last,
  output logic [2:0]             o_line_cnt,
  output logic                   o_err_short
);

  localparam int              NRAM     = ROWS - 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_W - 1);
  localparam logic [2:0]      FULL_CNT = 3'(ROWS - 1);

  logic [COL_W-1:0]  r_col;
  logic [2:0]        r_wr_line;
  logic [2:0]        r_line_cnt;
  logic              r_err_short;
  logic [DATA_W-1:0] r_row0;
  logic [2:0]        r_sel_line;
  logic [2:0]        r_sel_cnt;
  logic              r_out_valid;
  logic [COL_W-1:0]  r_out_col;
  logic              r_out_last;

  logic [COL_W-1:0]  w_col;
  logic [2:0]        w_wr_line;
  logic [2:0]        w_cnt;
  logic [2:0]        w_next_line;
  logic              w_col_last;
  logic              w_hs;
  logic              w_line_end;
  logic              w_short;
  logic              w_gate;
  logic              w_ram_en;
  logic [DATA_W-1:0] w_rd  [MAX_ROWS];
  logic [DATA_W-1:0] w_raw [MAX_ROWS];

  // sof acts on the same cycle's pixel, so every decision uses the post-sof view.
  assign w_col       = i_sof ? '0 : r_col;
  assign w_wr_line   = i_sof ? 3'd0 : r_wr_line;
  assign w_cnt       = i_sof ? 3'd0 : r_line_cnt;
  assign w_col_last  = (w_col == LAST_COL);
  assign w_hs        = i_rd_hs & ~i_sof & (i_wr_en | (r_col != '0));
  assign w_line_end  = (i_wr_en & w_col_last) | w_hs;
  assign w_short     = w_hs & ~(i_wr_en & w_col_last);
  assign w_next_line = (w_wr_line == 3'd0) ? 3'(ROWS - 2) : (w_wr_line - 3'd1);
  assign w_gate      = (PAD_MODE != PAD_NONE) || (w_cnt == FULL_CNT);
  assign w_ram_en    = i_wr_en & ~i_rst;

  for (genvar g = 0; g < MAX_ROWS; g++) begin : g_ram
    if (g < NRAM) begin : g_inst
      linebuf_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (LINE_W),
        .ADDR_W (COL_W)
      ) u_ram (
        .i_clk   (i_pclk),
        .i_rst   (i_rst),
        .i_en    (w_ram_en),
        .i_we    (w_wr_line == 3'(g)),
        .i_addr  (w_col),
        .i_wdata (i_wr_data),
        .o_rdata (w_rd[g])
      );
    end else begin : g_none
      assign w_rd[g] = '0;
    end
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      r_col       <= '0;
      r_wr_line   <= 3'd0;
      r_line_cnt  <= 3'd0;
      r_err_short <= 1'b0;
      r_row0      <= '0;
      r_sel_line  <= 3'd0;
      r_sel_cnt   <= 3'd0;
      r_out_valid <= 1'b0;
      r_out_col   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_line_end) begin
        r_col      <= '0;
        r_wr_line  <= w_next_line;
        r_line_cnt <= (w_cnt == FULL_CNT) ? FULL_CNT : (w_cnt + 3'd1);
      end else begin
        r_col      <= i_wr_en ? (w_col + 1'b1) : w_col;
        r_wr_line  <= w_wr_line;
        r_line_cnt <= w_cnt;
      end
      r_err_short <= (r_err_short & ~i_sof) | w_short;
      r_out_valid <= i_wr_en & w_gate & i_rd_en;
      // Ring position and fill level travel with the pixel to steer the column mux.
      if (i_wr_en) begin
        r_row0     <= i_wr_data;
        r_sel_line <= w_wr_line;
        r_sel_cnt  <= w_cnt;
        r_out_col  <= w_col;
        r_out_last <= w_col_last | (i_rd_hs & ~i_sof);
      end
    end
  end

  always_comb begin
    o_rows_out = '0;
    for (int k = 0; k < MAX_ROWS; k++) begin
      w_raw[k] = '0;
    end
    w_raw[0] = r_row0;
    for (int k = 1; k < ROWS; k++) begin
      w_raw[k] = w_rd[3'((int'(r_sel_line) + k) % NRAM)];
    end
    for (int k = 0; k < ROWS; k++) begin
      o_rows_out[k*DATA_W +: DATA_W] = w_raw[k];
      if (k > int'(r_sel_cnt)) begin
        if (PAD_MODE == PAD_ZERO) begin
          o_rows_out[k*DATA_W +: DATA_W] = '0;
        end else if (PAD_MODE == PAD_REPL) begin
          o_rows_out[k*DATA_W +: DATA_W] = w_raw[r_sel_cnt];
        end
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_col   = r_out_col;
  assign o_out_last  = r_out_last;
  assign o_line_cnt  = r_line_cnt;
  assign o_err_short = r_err_short;

endmodule

// File: tb/tb_conv_linebuf_k.sv
// Bench for conv_linebuf_k: four configurations share one stimulus stream, checked
// against directed vectors and a line-queue reference model.
module tb_conv_linebuf_k;
  import conv_pkg::*;

  localparam int NDUT = 4;
  localparam int cfgRows [NDUT] = '{3, 3, 3, 5};
  localparam int cfgLine [NDUT] = '{8, 8, 8, 4};
  localparam int cfgPad  [NDUT] = '{0, 1, 2, 0};

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        rst, sof, wrEn, rdHs, rdEn;
  logic [15:0] wrData;

  logic [47:0] rows0, rows1, rows2;
  logic [79:0] rows3;
  logic [2:0]  col0, col1, col2;
  logic [1:0]  col3;
  logic        outValid [NDUT];
  logic        outLast  [NDUT];
  logic [2:0]  lineCnt  [NDUT];
  logic        errShort [NDUT];

  conv_linebuf_k #(.DATA_W(16), .LINE_W(8), .ROWS(3), .PAD_MODE(0)) dut0 (
    .i_pclk(pclk), .i_rst(rst), .i_sof(sof), .i_wr_en(wrEn), .i_wr_data(wrData),
    .i_rd_hs(rdHs), .i_rd_en(rdEn), .o_rows_out(rows0), .o_out_valid(outValid[0]),
    .o_out_col(col0), .o_out_last(outLast[0]), .o_line_cnt(lineCnt[0]), .o_err_short(errShort[0]));
  conv_linebuf_k #(.DATA_W(16), .LINE_W(8), .ROWS(3), .PAD_MODE(1)) dut1 (
    .i_pclk(pclk), .i_rst(rst), .i_sof(sof), .i_wr_en(wrEn), .i_wr_data(wrData),
    .i_rd_hs(rdHs), .i_rd_en(rdEn), .o_rows_out(rows1), .o_out_valid(outValid[1]),
    .o_out_col(col1), .o_out_last(outLast[1]), .o_line_cnt(lineCnt[1]), .o_err_short(errShort[1]));
  conv_linebuf_k #(.DATA_W(16), .LINE_W(8), .ROWS(3), .PAD_MODE(2)) dut2 (
    .i_pclk(pclk), .i_rst(rst), .i_sof(sof), .i_wr_en(wrEn), .i_wr_data(wrData),
    .i_rd_hs(rdHs), .i_rd_en(rdEn), .o_rows_out(rows2), .o_out_valid(outValid[2]),
    .o_out_col(col2), .o_out_last(outLast[2]), .o_line_cnt(lineCnt[2]), .o_err_short(errShort[2]));
  conv_linebuf_k #(.DATA_W(16), .LINE_W(4), .ROWS(5), .PAD_MODE(0)) dut3 (
    .i_pclk(pclk), .i_rst(rst), .i_sof(sof), .i_wr_en(wrEn), .i_wr_data(wrData),
    .i_rd_hs(rdHs), .i_rd_en(rdEn), .o_rows_out(rows3), .o_out_valid(outValid[3]),
    .o_out_col(col3), .o_out_last(outLast[3]), .o_line_cnt(lineCnt[3]), .o_err_short(errShort[3]));

  int checks = 0;
  int errors = 0;

  // Reference model: each DUT keeps ROWS-1 physical line stores, ordered newest first.
  int  mCol [NDUT];
  int  mCnt [NDUT];
  bit  mErr [NDUT];
  int  order [NDUT][6];
  int  mem   [NDUT][6][8];
  bit  known [NDUT][6][8];
  bit  eV    [NDUT];
  int  eRow  [NDUT][7];
  bit  eKn   [NDUT][7];
  int  eCol  [NDUT];
  bit  eLast [NDUT];

  typedef struct {
    logic [15:0] pix;
    logic        expV0;
    int          expCol;
    logic        expLast;
    logic        chk0, chk1, chk2;
    logic [47:0] r0, r1, r2;
  } fillVec_t;
  fillVec_t fillTbl [24];

  function automatic logic [111:0] getRows(input int d);
    case (d)
      0: return {64'd0, rows0};
      1: return {64'd0, rows1};
      2: return {64'd0, rows2};
      default: return {32'd0, rows3};
    endcase
  endfunction

  function automatic int getCol(input int d);
    case (d)
      0: return int'(col0);
      1: return int'(col1);
      2: return int'(col2);
      default: return int'(col3);
    endcase
  endfunction

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkWide(input string name, input logic [111:0] act, input logic [111:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic resetOrder(input int d);
    for (int k = 1; k < cfgRows[d]; k++) begin
      order[d][k-1] = k % (cfgRows[d] - 1);
    end
  endtask

  task automatic modelStep(input int d);
    int r, l, p, c, n, tmp;
    int raw [7];
    bit rk [7];
    bit hsEff, lineEnd;
    r = cfgRows[d];
    l = cfgLine[d];
    p = cfgPad[d];
    eV[d] = 1'b0;
    if (rst) begin
      mCol[d] = 0;
      mCnt[d] = 0;
      mErr[d] = 1'b0;
      resetOrder(d);
      return;
    end
    if (sof) begin
      mCol[d] = 0;
      mCnt[d] = 0;
      mErr[d] = 1'b0;
      resetOrder(d);
    end
    c = mCol[d];
    n = mCnt[d];
    if (wrEn) begin
      raw[0] = int'(wrData);
      rk[0]  = 1'b1;
      for (int k = 1; k < r; k++) begin
        raw[k] = mem[d][order[d][k-1]][c];
        rk[k]  = known[d][order[d][k-1]][c];
      end
      for (int k = 0; k < r; k++) begin
        eRow[d][k] = raw[k];
        eKn[d][k]  = rk[k];
        if (k > n && p == 1) begin
          eRow[d][k] = 0;
          eKn[d][k]  = 1'b1;
        end else if (k > n && p == 2) begin
          eRow[d][k] = raw[n];
          eKn[d][k]  = rk[n];
        end
      end
      mem[d][order[d][r-2]][c]   = int'(wrData);
      known[d][order[d][r-2]][c] = 1'b1;
      eV[d]    = rdEn && (p != 0 || n == r - 1);
      eCol[d]  = c;
      eLast[d] = (c == l - 1) || (rdHs && !sof);
    end
    hsEff   = rdHs && !sof && (wrEn || c != 0);
    lineEnd = (wrEn && c == l - 1) || hsEff;
    if (hsEff && !(wrEn && c == l - 1)) mErr[d] = 1'b1;
    if (lineEnd) begin
      mCol[d] = 0;
      mCnt[d] = (n + 1 > r - 1) ? r - 1 : n + 1;
      tmp = order[d][r-2];
      for (int j = r - 2; j > 0; j--) order[d][j] = order[d][j-1];
      order[d][0] = tmp;
    end else begin
      mCnt[d] = n;
      mCol[d] = wrEn ? c + 1 : c;
    end
  endtask

  task automatic checkOutput(input int d);
    logic [111:0] act;
    act = getRows(d);
    checkVal($sformatf("d%0d out_valid", d), int'(outValid[d]), int'(eV[d]));
    checkVal($sformatf("d%0d line_cnt", d), int'(lineCnt[d]), mCnt[d]);
    checkVal($sformatf("d%0d err_short", d), int'(errShort[d]), int'(mErr[d]));
    if (eV[d]) begin
      checkVal($sformatf("d%0d out_col", d), getCol(d), eCol[d]);
      checkVal($sformatf("d%0d out_last", d), int'(outLast[d]), int'(eLast[d]));
      for (int k = 0; k < cfgRows[d]; k++) begin
        if (eKn[d][k]) checkVal($sformatf("d%0d row%0d", d, k), int'(act[k*16 +: 16]), eRow[d][k]);
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit w, input logic [15:0] dat,
                               input bit h, input bit re);
    rst = r; sof = s; wrEn = w; wrData = dat; rdHs = h; rdEn = re;
    for (int d = 0; d < NDUT; d++) modelStep(d);
    @(posedge pclk);
    #1;
    for (int d = 0; d < NDUT; d++) checkOutput(d);
  endtask

  task automatic pixel(input logic [15:0] dat);
    applyStimulus(1'b0, 1'b0, 1'b1, dat, 1'b0, 1'b1);
  endtask

  task automatic runFill();
    for (int i = 0; i < 24; i++) begin
      pixel(fillTbl[i].pix);
      checkVal("fill valid d0", int'(outValid[0]), int'(fillTbl[i].expV0));
      checkVal("fill valid d1", int'(outValid[1]), 1);
      checkVal("fill col d1", int'(col1), fillTbl[i].expCol);
      checkVal("fill last d1", int'(outLast[1]), int'(fillTbl[i].expLast));
      if (fillTbl[i].chk0) checkWide("fill rows d0", {64'd0, rows0}, {64'd0, fillTbl[i].r0});
      if (fillTbl[i].chk1) checkWide("fill rows d1", {64'd0, rows1}, {64'd0, fillTbl[i].r1});
      if (fillTbl[i].chk2) checkWide("fill rows d2", {64'd0, rows2}, {64'd0, fillTbl[i].r2});
    end
  endtask

  initial begin
    for (int i = 0; i < 24; i++) begin
      fillTbl[i].pix     = 16'(i + 1);
      fillTbl[i].expV0   = (i >= 16);
      fillTbl[i].expCol  = i % 8;
      fillTbl[i].expLast = (i % 8 == 7);
      fillTbl[i].chk0 = 1'b0; fillTbl[i].chk1 = 1'b0; fillTbl[i].chk2 = 1'b0;
      fillTbl[i].r0 = '0; fillTbl[i].r1 = '0; fillTbl[i].r2 = '0;
    end
    fillTbl[0].chk1  = 1'b1; fillTbl[0].r1  = {16'd0, 16'd0, 16'd1};
    fillTbl[0].chk2  = 1'b1; fillTbl[0].r2  = {16'd1, 16'd1, 16'd1};
    fillTbl[8].chk1  = 1'b1; fillTbl[8].r1  = {16'd0, 16'd1, 16'd9};
    fillTbl[9].chk2  = 1'b1; fillTbl[9].r2  = {16'd2, 16'd2, 16'd10};
    fillTbl[16].chk0 = 1'b1; fillTbl[16].r0 = {16'd1, 16'd9, 16'd17};
    fillTbl[16].chk1 = 1'b1; fillTbl[16].r1 = {16'd1, 16'd9, 16'd17};
    fillTbl[16].chk2 = 1'b1; fillTbl[16].r2 = {16'd1, 16'd9, 16'd17};
    for (int d = 0; d < NDUT; d++) begin
      for (int b = 0; b < 6; b++) for (int c = 0; c < 8; c++) known[d][b][c] = 1'b0;
      resetOrder(d);
    end

    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    for (int d = 0; d < NDUT; d++) begin
      checkWide($sformatf("reset rows d%0d", d), getRows(d), '0);
      checkVal($sformatf("reset col d%0d", d), getCol(d), 0);
      checkVal($sformatf("reset last d%0d", d), int'(outLast[d]), 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1);

    $display("[TB] fill test");
    runFill();

    $display("[TB] short line test");
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) pixel(16'(100 + i));
    applyStimulus(1'b0, 1'b0, 1'b1, 16'd104, 1'b1, 1'b1);
    checkVal("short err d0", int'(errShort[0]), 1);
    checkVal("short cnt d0", int'(lineCnt[0]), 1);
    for (int i = 0; i < 8; i++) begin
      pixel(16'(200 + i));
      if (i == 0) checkVal("short next col d1", int'(col1), 0);
    end
    checkVal("short full cnt d0", int'(lineCnt[0]), 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    checkVal("sof clr err d0", int'(errShort[0]), 0);
    checkVal("sof clr cnt d0", int'(lineCnt[0]), 0);

    $display("[TB] simultaneous sof test");
    for (int i = 0; i < 8; i++) pixel(16'(300 + i));
    checkVal("pre-sof cnt d0", int'(lineCnt[0]), 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0055, 1'b1, 1'b1);
    checkVal("sof+hs col d1", int'(col1), 0);
    checkVal("sof+hs last d1", int'(outLast[1]), 0);
    checkVal("sof+hs cnt d0", int'(lineCnt[0]), 0);
    checkVal("sof+hs err d0", int'(errShort[0]), 0);
    pixel(16'h0066);
    checkVal("after sof col d1", int'(col1), 1);
    checkWide("after sof rows d1", {64'd0, rows1}, {64'd0, 16'd0, 16'd0, 16'h0066});
    checkWide("after sof rows d2", {64'd0, rows2}, {64'd0, 16'h0066, 16'h0066, 16'h0066});

    $display("[TB] mid-line reset test");
    for (int i = 0; i < 14; i++) pixel(16'(400 + i));
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0077, 1'b0, 1'b1);
    for (int d = 0; d < 3; d++) begin
      checkWide($sformatf("rst rows d%0d", d), getRows(d), '0);
      checkVal($sformatf("rst valid d%0d", d), int'(outValid[d]), 0);
      checkVal($sformatf("rst col d%0d", d), getCol(d), 0);
      checkVal($sformatf("rst cnt d%0d", d), int'(lineCnt[d]), 0);
    end
    runFill();

    $display("[TB] ring wrap test");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    for (int ln = 0; ln < 10; ln++) begin
      for (int c = 0; c < 4; c++) begin
        bit re;
        re = !(ln == 8 && c == 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'(ln * 16 + c), 1'b0, re);
        checkVal("ring valid d3", int'(outValid[3]), int'(ln >= 4 && re));
        if (ln == 9 && c == 2)
          checkWide("ring rows d3", {32'd0, rows3},
                    {32'd0, 16'd82, 16'd98, 16'd114, 16'd130, 16'd146});
      end
    end

    $display("[TB] random test");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(199) == 0, $urandom_range(59) == 0, $urandom_range(3) != 0,
                    16'($urandom), $urandom_range(19) == 0, $urandom_range(7) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
